maze_dfs_carver: RTL and testbench

MAZE_DFS_CARVER -- requirements
Module: maze_dfs_carver

---
 rtl/maze_pkg.sv | 33 +++
 rtl/maze_lfsr.sv | 33 +++
 rtl/maze_dfs_carver.sv | 216 +++++++++++++++++++++
 tb/tb_maze_dfs_carver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg -- shared definitions for the DFS maze carver.
//   state_t            : carver FSM state encoding
//   dir_t              : search direction encoding (0=up, 1=right, 2=down, 3=left)
//   CELL_WALL/CELL_PATH: values stored per cell in maze_data
//   LFSR_DEFAULT_SEED  : LFSR reset value, also substituted for a zero seed
//   LFSR_TAPS          : Galois feedback mask for x^16+x^14+x^13+x^11+1
package maze_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PICK  = 3'd2,
    ST_CHECK = 3'd3,
    ST_CARVE = 3'd4,
    ST_POP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam logic CELL_WALL = 1'b0;
  localparam logic CELL_PATH = 1'b1;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Right-shifting Galois form: bits for x^16, x^14, x^13, x^11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/maze_lfsr.sv
// maze_lfsr -- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Steps every clock; a load request replaces the step for that cycle.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (register <= LFSR_DEFAULT_SEED)
//   load       : load load_value instead of stepping
//   load_value : value to load
//   rnd        : two low-order register bits, used as a random direction
module maze_lfsr
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [1:0]  rnd
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      lfsr_reg <= load_value;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign rnd = lfsr_reg[1:0];

endmodule

// File: rtl/maze_dfs_carver.sv
// maze_dfs_carver -- carves a perfect maze (spanning tree over the odd/odd
// node grid) with an iterative randomized depth-first search.
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   start            : one-cycle generate request (accepted in IDLE or DONE)
//   seed             : LFSR seed, sampled with start (0 means LFSR_DEFAULT_SEED)
//   start_x, start_y : first node, sampled with start; must be an odd node coordinate
//   busy             : high from accept until done
//   done             : one-cycle pulse when generation completes
//   err              : one-cycle pulse when start is rejected for a bad coordinate
//   maze_data        : cell (x,y) at bit x+MAZE_W*y, 1=path, 0=wall
//   carved_cnt       : number of path cells set so far
module maze_dfs_carver
  import maze_pkg::*;
#(
  parameter int MAZE_W = 16,
  parameter int MAZE_H = 16,
  parameter int CW     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              seed,
  input  logic [CW-1:0]            start_x,
  input  logic [CW-1:0]            start_y,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [MAZE_W*MAZE_H-1:0] maze_data,
  output logic [15:0]              carved_cnt
);

  localparam int NODES = ((MAZE_W - 1) / 2) * ((MAZE_H - 1) / 2);
  localparam int CELLS = MAZE_W * MAZE_H;
  localparam int IW    = $clog2(CELLS);
  localparam int AW    = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int SPW   = $clog2(NODES + 1);
  localparam int CW1   = CW + 1;

  // Neighbour arithmetic is done one bit wider so cur-2 at the left/top
  // edge becomes a huge value that fails the upper bound, never wraps onto
  // a real cell.
  localparam logic [CW:0]    NODE_MIN   = CW1'(1);
  localparam logic [CW:0]    NODE_X_MAX = CW1'(MAZE_W - 2);
  localparam logic [CW:0]    NODE_Y_MAX = CW1'(MAZE_H - 2);
  localparam logic [CW:0]    STEP       = CW1'(2);
  localparam logic [CW-1:0]  X_LIM      = CW'(MAZE_W - 1);
  localparam logic [CW-1:0]  Y_LIM      = CW'(MAZE_H - 1);
  localparam logic [SPW-1:0] SP_ONE     = SPW'(1);

  state_t            state;
  dir_t              dir;
  logic [CW-1:0]     cur_x;
  logic [CW-1:0]     cur_y;
  logic [SPW-1:0]    sp;
  logic [2*CW-1:0]   stack [NODES];
  logic [2*CW-1:0]   stack_top;
  logic [SPW-1:0]    sp_dec;

  logic              accept;
  logic              start_ok;
  logic [15:0]       load_value;
  logic [1:0]        rnd;

  logic [CW:0]       tgt_x [4];
  logic [CW:0]       tgt_y [4];
  logic [3:0]        free;
  logic [CW:0]       mid_x;
  logic [CW:0]       mid_y;
  logic              scan_found;
  dir_t              scan_dir;
  logic [1:0]        probe;

  function automatic logic [IW-1:0] cell_idx(input logic [CW:0] x, input logic [CW:0] y);
    logic [31:0] lin;
    lin = 32'(x) + 32'(MAZE_W) * 32'(y);
    return lin[IW-1:0];
  endfunction

  assign accept     = start && (state == ST_IDLE || state == ST_DONE);
  assign start_ok   = start_x[0] && start_y[0] && (start_x < X_LIM) && (start_y < Y_LIM);
  assign load_value = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

  maze_lfsr u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_value (load_value),
    .rnd        (rnd)
  );

  // Candidate target and "unvisited node" flag for each of the four directions.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dir
    localparam dir_t D = dir_t'(gi);
    logic [CW:0] tx;
    logic [CW:0] ty;
    logic        in_range;

    assign tx = (D == DIR_RIGHT) ? {1'b0, cur_x} + STEP :
                (D == DIR_LEFT)  ? {1'b0, cur_x} - STEP : {1'b0, cur_x};
    assign ty = (D == DIR_DOWN)  ? {1'b0, cur_y} + STEP :
                (D == DIR_UP)    ? {1'b0, cur_y} - STEP : {1'b0, cur_y};
    assign in_range = (tx >= NODE_MIN) && (tx <= NODE_X_MAX) &&
                      (ty >= NODE_MIN) && (ty <= NODE_Y_MAX);
    assign free[gi]  = in_range && (maze_data[cell_idx(tx, ty)] == CELL_WALL);
    assign tgt_x[gi] = tx;
    assign tgt_y[gi] = ty;
  end

  // The dir, dir+1, dir+2, dir+3 rotation is resolved in a single CHECK
  // cycle: the first free direction in that order is the one the step-by-step
  // search would reach, and no free direction means all four tries fail.
  always_comb begin
    scan_found = 1'b0;
    scan_dir   = dir;
    probe      = dir;
    for (int k = 0; k < 4; k++) begin
      probe = dir + 2'(k);
      if (!scan_found && free[probe]) begin
        scan_found = 1'b1;
        scan_dir   = dir_t'(probe);
      end
    end
  end

  // Corridor cell is halfway between cur and target.
  assign mid_x = ({1'b0, cur_x} + tgt_x[dir]) >> 1;
  assign mid_y = ({1'b0, cur_y} + tgt_y[dir]) >> 1;

  assign sp_dec    = sp - SP_ONE;
  assign stack_top = stack[sp_dec[AW-1:0]];

  // Return stack: no reset needed, only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (state == ST_CARVE) begin
      stack[sp[AW-1:0]] <= {cur_x, cur_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dir        <= DIR_UP;
      cur_x      <= '0;
      cur_y      <= '0;
      sp         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      maze_data  <= '0;
      carved_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (start_ok) begin
              // Start coordinate is captured here so CLEAR can use it
              // even though the start inputs may have moved on.
              cur_x <= start_x;
              cur_y <= start_y;
              busy  <= 1'b1;
              state <= ST_CLEAR;
            end else begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_CLEAR: begin
          maze_data <= '0;
          maze_data[cell_idx({1'b0, cur_x}, {1'b0, cur_y})] <= CELL_PATH;
          sp         <= '0;
          carved_cnt <= 16'd1;
          state      <= ST_PICK;
        end
        ST_PICK: begin
          dir   <= dir_t'(rnd);
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (scan_found) begin
            dir   <= scan_dir;
            state <= ST_CARVE;
          end else begin
            state <= ST_POP;
          end
        end
        ST_CARVE: begin
          maze_data[cell_idx(mid_x, mid_y)]           <= CELL_PATH;
          maze_data[cell_idx(tgt_x[dir], tgt_y[dir])] <= CELL_PATH;
          sp         <= sp + SP_ONE;
          cur_x      <= tgt_x[dir][CW-1:0];
          cur_y      <= tgt_y[dir][CW-1:0];
          carved_cnt <= carved_cnt + 16'd2;
          state      <= ST_PICK;
        end
        ST_POP: begin
          if (sp == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            cur_x <= stack_top[2*CW-1:CW];
            cur_y <= stack_top[CW-1:0];
            sp    <= sp_dec;
            state <= ST_PICK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_dfs_carver.sv
// Self-checking bench for maze_dfs_carver: a 5x5 instance and a default
// 16x16 instance share clock and reset; each task covers one scenario.
module tb_maze_dfs_carver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         start5, busy5, done5, err5;
  logic [15:0]  seed5, cnt5;
  logic [2:0]   sx5, sy5;
  logic [24:0]  maze5;

  logic         start16, busy16, done16, err16;
  logic [15:0]  seed16, cnt16;
  logic [5:0]   sx16, sy16;
  logic [255:0] maze16;

  int checks   = 0;
  int failures = 0;

  logic [255:0] golden1;

  maze_dfs_carver #(.MAZE_W(5), .MAZE_H(5), .CW(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .seed(seed5),
    .start_x(sx5), .start_y(sy5), .busy(busy5), .done(done5), .err(err5),
    .maze_data(maze5), .carved_cnt(cnt5)
  );

  maze_dfs_carver dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .seed(seed16),
    .start_x(sx16), .start_y(sy16), .busy(busy16), .done(done16), .err(err16),
    .maze_data(maze16), .carved_cnt(cnt16)
  );

  function automatic int bfs_nodes(input logic [255:0] m);
    bit seen [256];
    int q[$];
    int n, idx, x, y;
    n = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    if (m[17] !== 1'b1) return 0;
    seen[17] = 1'b1;
    q.push_back(17);
    while (q.size() > 0) begin
      idx = q.pop_front();
      x = idx % 16;
      y = idx / 16;
      if ((x % 2 == 1) && (y % 2 == 1)) n++;
      if (y > 0  && m[idx-16] === 1'b1 && !seen[idx-16]) begin seen[idx-16] = 1'b1; q.push_back(idx-16); end
      if (y < 15 && m[idx+16] === 1'b1 && !seen[idx+16]) begin seen[idx+16] = 1'b1; q.push_back(idx+16); end
      if (x > 0  && m[idx-1]  === 1'b1 && !seen[idx-1])  begin seen[idx-1]  = 1'b1; q.push_back(idx-1);  end
      if (x < 15 && m[idx+1]  === 1'b1 && !seen[idx+1])  begin seen[idx+1]  = 1'b1; q.push_back(idx+1);  end
    end
    return n;
  endfunction

  function automatic int edge_paths(input logic [255:0] m);
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (((i % 16) == 15 || (i / 16) == 15) && m[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int even_even_paths(input logic [255:0] m);
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (((i % 16) % 2 == 0) && ((i / 16) % 2 == 0) && m[i] !== 1'b0) n++;
    return n;
  endfunction

  task automatic launch5(input logic [15:0] s, input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    seed5 = s; sx5 = x; sy5 = y; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
  endtask

  task automatic launch16(input logic [15:0] s, input logic [5:0] x, input logic [5:0] y);
    @(negedge clk);
    seed16 = s; sx16 = x; sy16 = y; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // Called right after a launch: cyc counts cycles since the accept edge.
  task automatic wait_done5(input int bound, output int cyc, output bit got);
    cyc = 1; got = 1'b0;
    while (!got && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (done5 === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_done16(input int bound, output int cyc, output bit got);
    cyc = 1; got = 1'b0;
    while (!got && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (done16 === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start5 = 1'b0; seed5 = '0; sx5 = '0; sy5 = '0;
    start16 = 1'b0; seed16 = '0; sx16 = '0; sy16 = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy16); end
    checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done16); end
    checks++; if (err16 !== 1'b0)  begin failures++; $display("FAIL reset_err: got %0b expected 0", err16); end
    checks++; if (maze16 !== '0)   begin failures++; $display("FAIL reset_maze16: got %h expected 0", maze16); end
    checks++; if (cnt16 !== 16'd0) begin failures++; $display("FAIL reset_cnt16: got %0d expected 0", cnt16); end
    checks++; if (maze5 !== '0)    begin failures++; $display("FAIL reset_maze5: got %h expected 0", maze5); end
    checks++; if (cnt5 !== 16'd0)  begin failures++; $display("FAIL reset_cnt5: got %0d expected 0", cnt5); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs idle and cleared");
  endtask

  task automatic test_small_maze();
    int cyc; bit got;
    int nodes_x [4] = '{1, 3, 1, 3};
    int nodes_y [4] = '{1, 1, 3, 3};
    logic [24:0] border;
    launch5(16'h1234, 3'd1, 3'd1);
    wait_done5(36, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL small_done: no done within 36 cycles (waited %0d)", cyc); end
    checks++; if (cnt5 !== 16'd7) begin failures++; $display("FAIL small_cnt: got %0d expected 7", cnt5); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (maze5[nodes_x[i] + 5*nodes_y[i]] !== 1'b1) begin
        failures++; $display("FAIL small_node(%0d,%0d): got %b expected 1", nodes_x[i], nodes_y[i], maze5[nodes_x[i] + 5*nodes_y[i]]);
      end
    end
    border = '0;
    for (int i = 0; i < 25; i++)
      if ((i % 5) == 0 || (i % 5) == 4 || (i / 5) == 0 || (i / 5) == 4) border[i] = 1'b1;
    checks++; if ((maze5 & border) !== '0) begin failures++; $display("FAIL small_border: path bits %h expected 0", maze5 & border); end
    // First pick is "down" from (1,1); the rest of the 5x5 tree is forced.
    checks++; if (maze5 !== 25'h0072940) begin failures++; $display("FAIL small_maze: got %h expected 0072940", maze5); end
    checks++; if (busy5 !== 1'b0) begin failures++; $display("FAIL small_busy: got %0b expected 0", busy5); end
    @(negedge clk);
    checks++; if (done5 !== 1'b0) begin failures++; $display("FAIL small_done_pulse: got %0b expected 0", done5); end
    $display("small_maze: seed 1234 done after %0d cycles cnt=%0d maze=%h", cyc, cnt5, maze5);
  endtask

  task automatic test_full_maze();
    int cyc; bit got;
    launch16(16'h0001, 6'd1, 6'd1);
    wait_done16(396, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL full_done: no done within 396 cycles (waited %0d)", cyc); end
    checks++; if (cnt16 !== 16'd97) begin failures++; $display("FAIL full_cnt: got %0d expected 97", cnt16); end
    checks++; if ($countones(maze16) != 97) begin failures++; $display("FAIL full_popcount: got %0d expected 97", $countones(maze16)); end
    checks++; if (bfs_nodes(maze16) != 49) begin failures++; $display("FAIL full_bfs: reached %0d nodes expected 49", bfs_nodes(maze16)); end
    checks++; if (edge_paths(maze16) != 0) begin failures++; $display("FAIL full_edge: got %0d path cells on x/y=15 expected 0", edge_paths(maze16)); end
    checks++; if (even_even_paths(maze16) != 0) begin failures++; $display("FAIL full_pillars: got %0d even/even path cells expected 0", even_even_paths(maze16)); end
    checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL full_busy: got %0b expected 0", busy16); end
    golden1 = maze16;
    $display("full_maze: seed 0001 done after %0d cycles cnt=%0d", cyc, cnt16);
  endtask

  task automatic test_bad_start();
    logic [5:0] bx [3] = '{6'd2, 6'd15, 6'd1};
    logic [5:0] by [3] = '{6'd1, 6'd1,  6'd0};
    logic [255:0] snap;
    int errs; bit busy_seen;
    for (int v = 0; v < 3; v++) begin
      snap = maze16;
      @(negedge clk);
      sx16 = bx[v]; sy16 = by[v]; seed16 = 16'h0042; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      errs = 0; busy_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (err16 === 1'b1) errs++;
        if (busy16 !== 1'b0) busy_seen = 1'b1;
        @(negedge clk);
      end
      checks++; if (errs != 1) begin failures++; $display("FAIL bad_err(%0d,%0d): got %0d pulses expected 1", bx[v], by[v], errs); end
      checks++; if (busy_seen) begin failures++; $display("FAIL bad_busy(%0d,%0d): got busy high expected 0", bx[v], by[v]); end
      checks++; if (maze16 !== snap) begin failures++; $display("FAIL bad_maze(%0d,%0d): maze_data changed", bx[v], by[v]); end
      $display("bad_start: (%0d,%0d) err pulses=%0d", bx[v], by[v], errs);
    end
  endtask

  task automatic test_seed_zero();
    int cyc; bit got;
    logic [255:0] snap_a;
    launch16(16'h0000, 6'd1, 6'd1);
    wait_done16(396, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL seed0_done: no done within 396 cycles"); end
    snap_a = maze16;
    launch16(16'hACE1, 6'd1, 6'd1);
    wait_done16(396, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL seedace1_done: no done within 396 cycles"); end
    checks++; if (maze16 !== snap_a) begin failures++; $display("FAIL seed0_equiv: got %h expected %h", maze16, snap_a); end
    $display("seed_zero: seed 0 vs ACE1 cnt=%0d", cnt16);
  endtask

  task automatic test_back_to_back();
    int cyc; bit got;
    int dones;
    logic [255:0] snap;
    launch16(16'h00C3, 6'd1, 6'd1);
    wait_done16(396, cyc, got);
    snap = maze16;
    launch16(16'h00C3, 6'd1, 6'd1);
    repeat (9) @(negedge clk);
    seed16 = 16'h5555; sx16 = 6'd3; sy16 = 6'd5; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait_done16(396, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL busy_start_done: no done within 396 cycles"); end
    checks++; if (maze16 !== snap) begin failures++; $display("FAIL busy_start_maze: got %h expected %h", maze16, snap); end
    checks++; if (cnt16 !== 16'd97) begin failures++; $display("FAIL busy_start_cnt: got %0d expected 97", cnt16); end
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done16 === 1'b1 || busy16 !== 1'b0) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL busy_start_rerun: got %0d extra busy/done cycles expected 0", dones); end
    $display("back_to_back: start during busy ignored, cnt=%0d", cnt16);
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit got;
    int stray;
    launch16(16'h0001, 6'd1, 6'd1);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (maze16 !== '0) begin failures++; $display("FAIL midrst_maze: got %h expected 0", maze16); end
    checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", busy16); end
    checks++; if (cnt16 !== 16'd0) begin failures++; $display("FAIL midrst_cnt: got %0d expected 0", cnt16); end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy16 !== 1'b0 || done16 !== 1'b0 || maze16 !== '0) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL midrst_idle: got %0d active cycles expected 0", stray); end
    launch16(16'h0001, 6'd1, 6'd1);
    wait_done16(396, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL midrst_rerun_done: no done within 396 cycles"); end
    checks++; if (cnt16 !== 16'd97) begin failures++; $display("FAIL midrst_rerun_cnt: got %0d expected 97", cnt16); end
    checks++; if (maze16 !== golden1) begin failures++; $display("FAIL midrst_rerun_maze: got %h expected %h", maze16, golden1); end
    $display("reset_mid_run: abandoned at cycle 20, rerun done after %0d cycles", cyc);
  endtask

  initial begin
    test_reset();
    test_small_maze();
    test_full_maze();
    test_bad_start();
    test_seed_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
